wallace_reduce_pipe: RTL

Pipelined 8x8 unsigned partial-product generator and Wallace-tree reducer. Accepts operand pairs with a valid/ready handshake and emits two 16-bit carry-save rows whose sum is the exact product. Sits directly upstream of the team's 16-bit two-level CLA final adder: `row_s` and `row_c` drive its `a` and `b` inputs, and `c0` is tied to 0. Sustains one product per cycle with full backpressure support.

---
 rtl/wallace_reduce_pipe_if.sv | 54 +++++
 rtl/wallace_reduce_pipe.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wallace_reduce_pipe_if.sv
// ---------------------------------------------------------------------------
// wallace_reduce_pipe_if
//
// Purpose: groups the operand-side and row-side handshakes of the
// wallace_reduce_pipe multiplier front end into one bundle.
//
// Signals:
//   in_valid  (master -> slave)  operand pair on a/b is valid
//   in_ready  (slave -> master)  block accepts the pair this cycle
//   a, b      (master -> slave)  8-bit unsigned operands
//   out_valid (slave -> master)  row_s/row_c hold a valid carry-save pair
//   out_ready (master -> slave)  downstream consumes the rows this cycle
//   row_s     (slave -> master)  16-bit carry-save sum row
//   row_c     (slave -> master)  16-bit carry-save carry row, at its weight
//   busy      (slave -> master)  at least one pipeline stage is occupied
//
// The slave modport is the multiplier's view; the master modport is the view
// of whatever surrounds it (operand source plus row consumer).
// ---------------------------------------------------------------------------
interface wallace_reduce_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] row_s;
    logic [15:0] row_c;
    logic        busy;

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output row_s,
        output row_c,
        output busy
    );

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  row_s,
        input  row_c,
        input  busy
    );
endinterface

// File: rtl/wallace_reduce_pipe.sv
// ---------------------------------------------------------------------------
// wallace_reduce_pipe
//
// Purpose: pipelined 8x8 unsigned partial-product generator and Wallace-tree
// reducer. Each accepted operand pair leaves as two 16-bit carry-save rows
// (row_s, row_c) whose integer sum is exactly a*b, ready to feed a 16-bit
// carry-lookahead adder with carry-in tied low.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; clears every stage and holds
//          in_ready low while asserted
//   bus    wallace_reduce_pipe_if.slave
//            in_valid/in_ready/a/b        operand handshake
//            out_valid/out_ready/row_s/row_c  row handshake
//            busy                          any stage occupied
//
// Pipeline:
//   stage 1  eight partial-product rows pp[i] = {8{b[i]}} & a   (v1)
//   stage 2  Wallace levels 1-2: 8 -> 6 -> 4 rows                (v2)
//   stage 3  Wallace levels 3-4: 4 -> 3 -> 2 rows                (v3)
//
// Each stage advances when it is empty or the stage after it advances, so a
// full pipeline accepts and emits on the same edge, and bubbles collapse.
// The only combinational input-to-output path is out_ready -> in_ready.
// ---------------------------------------------------------------------------
module wallace_reduce_pipe (
    input  logic                    clk,
    input  logic                    rst_n,
    wallace_reduce_pipe_if.slave    bus
);

    // 3:2 compressor applied column-wise across three rows. The carry row is
    // returned already shifted to the next column. Because every row stays
    // non-negative and the rows of a level always sum to a*b < 2^16, the bit
    // shifted out of position 15 is provably zero.
    function automatic logic [15:0] fa_sum(input logic [15:0] x,
                                           input logic [15:0] y,
                                           input logic [15:0] z);
        return x ^ y ^ z;
    endfunction

    function automatic logic [15:0] fa_carry(input logic [15:0] x,
                                             input logic [15:0] y,
                                             input logic [15:0] z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    // 2:2 half-adder compressor for a leftover pair of rows.
    function automatic logic [15:0] ha_sum(input logic [15:0] x,
                                           input logic [15:0] y);
        return x ^ y;
    endfunction

    function automatic logic [15:0] ha_carry(input logic [15:0] x,
                                             input logic [15:0] y);
        return (x & y) << 1;
    endfunction

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic [7:0][7:0]  pp_q,   pp_d;     // stage 1: unshifted partial products
    logic             v1_q,   v1_d;
    logic [3:0][15:0] red4_q, red4_d;   // stage 2: four weighted rows
    logic             v2_q,   v2_d;
    logic [15:0]      rs_q,   rs_d;     // stage 3: carry-save pair
    logic [15:0]      rc_q,   rc_d;
    logic             v3_q,   v3_d;
    logic             busy_q, busy_d;

    // ------------------------------------------------------------------
    // Stall chain: a stage may load when it is empty or its successor
    // is moving on this edge.
    // ------------------------------------------------------------------
    logic adv1, adv2, adv3;

    assign adv3 = !v3_q || bus.out_ready;
    assign adv2 = !v2_q || adv3;
    assign adv1 = !v1_q || adv2;

    assign bus.in_ready = rst_n && adv1;

    // ------------------------------------------------------------------
    // Stage 1 next state: partial-product rows
    // ------------------------------------------------------------------
    always_comb begin
        pp_d = pp_q;
        v1_d = v1_q;
        if (adv1) begin
            // An empty predecessor still loads data here; it is don't-care
            // while v1 is low.
            v1_d = bus.in_valid;
            for (int i = 0; i < 8; i++) begin
                pp_d[i] = {8{bus.b[i]}} & bus.a;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 next state: Wallace levels 1 and 2 (8 -> 6 -> 4 rows)
    // ------------------------------------------------------------------
    logic [7:0][15:0] lvl0;
    logic [5:0][15:0] lvl1;
    logic [3:0][15:0] lvl2;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lvl0[i] = {8'h00, pp_q[i]} << i;
        end

        // Level 1: two full-adder groups of three, one half-adder pair.
        lvl1[0] = fa_sum  (lvl0[0], lvl0[1], lvl0[2]);
        lvl1[1] = fa_carry(lvl0[0], lvl0[1], lvl0[2]);
        lvl1[2] = fa_sum  (lvl0[3], lvl0[4], lvl0[5]);
        lvl1[3] = fa_carry(lvl0[3], lvl0[4], lvl0[5]);
        lvl1[4] = ha_sum  (lvl0[6], lvl0[7]);
        lvl1[5] = ha_carry(lvl0[6], lvl0[7]);

        // Level 2: two full-adder groups of three.
        lvl2[0] = fa_sum  (lvl1[0], lvl1[1], lvl1[2]);
        lvl2[1] = fa_carry(lvl1[0], lvl1[1], lvl1[2]);
        lvl2[2] = fa_sum  (lvl1[3], lvl1[4], lvl1[5]);
        lvl2[3] = fa_carry(lvl1[3], lvl1[4], lvl1[5]);
    end

    always_comb begin
        red4_d = red4_q;
        v2_d   = v2_q;
        if (adv2) begin
            red4_d = lvl2;
            v2_d   = v1_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3 next state: Wallace levels 3 and 4 (4 -> 3 -> 2 rows)
    // ------------------------------------------------------------------
    logic [2:0][15:0] lvl3;
    logic [15:0]      lvl4_s, lvl4_c;

    always_comb begin
        // Level 3: one full-adder group; the fourth row passes through.
        lvl3[0] = fa_sum  (red4_q[0], red4_q[1], red4_q[2]);
        lvl3[1] = fa_carry(red4_q[0], red4_q[1], red4_q[2]);
        lvl3[2] = red4_q[3];

        // Level 4: final full-adder group leaves the carry-save pair.
        lvl4_s  = fa_sum  (lvl3[0], lvl3[1], lvl3[2]);
        lvl4_c  = fa_carry(lvl3[0], lvl3[1], lvl3[2]);
    end

    always_comb begin
        rs_d = rs_q;
        rc_d = rc_q;
        v3_d = v3_q;
        if (adv3) begin
            rs_d = lvl4_s;
            rc_d = lvl4_c;
            v3_d = v2_q;
        end
    end

    // busy is registered from the next-state valid flags so that it is a
    // clean flop output rather than an OR of flops.
    assign busy_d = v1_d || v2_d || v3_d;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pp_q   <= '0;
            v1_q   <= 1'b0;
            red4_q <= '0;
            v2_q   <= 1'b0;
            rs_q   <= '0;
            rc_q   <= '0;
            v3_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            pp_q   <= pp_d;
            v1_q   <= v1_d;
            red4_q <= red4_d;
            v2_q   <= v2_d;
            rs_q   <= rs_d;
            rc_q   <= rc_d;
            v3_q   <= v3_d;
            busy_q <= busy_d;
        end
    end

    assign bus.out_valid = v3_q;
    assign bus.row_s     = rs_q;
    assign bus.row_c     = rc_q;
    assign bus.busy      = busy_q;

endmodule
